// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: weight preload,
// skewed switch/valid generation at the west edge and result tagging at the south edge.
module systolic_ctrl #(
  parameter int N  = 2,
  parameter int CW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = CW + $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   num_vecs,
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [RW-1:0]   w_rd_row,
  output logic [N-1:0]    accept_w,
  output logic [N-1:0]    switch_row,
  output logic [N-1:0]    valid_row,
  output logic [N*CW-1:0] in_idx,
  output logic [N-1:0]    out_valid,
  output logic [N*CW-1:0] out_idx
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

  state_t        state;
  logic [TW-1:0] cnt;
  logic [CW-1:0] m_lat;
  logic [TW-1:0] m_ext;
  logic [TW-1:0] last_t;
  logic          stream;

  assign m_ext  = TW'(m_lat);
  // Last stream cycle is the final psum leaving the east-most column.
  assign last_t = TW'(2 * N - 2) + m_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      m_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            m_lat <= num_vecs;
            state <= (num_vecs == '0) ? DONE : LOAD_W;
          end
        end
        LOAD_W: begin
          if (cnt == TW'(N - 1)) begin
            cnt   <= '0;
            state <= STREAM;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        STREAM: begin
          if (cnt == last_t) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == LOAD_W) || (state == STREAM);
  assign done     = (state == DONE);
  assign w_rd_en  = (state == LOAD_W);
  assign accept_w = {N{w_rd_en}};
  // Bottom tile row goes in first so it ends up in the last PE row.
  assign w_rd_row = w_rd_en ? RW'(TW'(N - 1) - cnt) : '0;
  assign stream   = (state == STREAM);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam logic [TW-1:0] OFS_IN  = TW'(gi);
    localparam logic [TW-1:0] OFS_OUT = TW'(N + gi);

    logic [TW-1:0] rel_in;
    logic [TW-1:0] rel_out;
    logic          v_in;
    logic          v_out;

    assign rel_in  = cnt - OFS_IN;
    assign rel_out = cnt - OFS_OUT;
    assign v_in    = stream && (cnt >= OFS_IN) && (rel_in < m_ext);
    // Column gi output trails row entry by N psum hops plus gi east hops.
    assign v_out   = stream && (cnt >= OFS_OUT) && (rel_out < m_ext);

    assign switch_row[gi]        = stream && (cnt == OFS_IN);
    assign valid_row[gi]         = v_in;
    assign in_idx[gi*CW +: CW]   = v_in ? rel_in[CW-1:0] : '0;
    assign out_valid[gi]         = v_out;
    assign out_idx[gi*CW +: CW]  = v_out ? rel_out[CW-1:0] : '0;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: N=2 and N=4 instances, expected events queued
// from a per-job timeline model and matched by a per-cycle monitor.
module tb_systolic_ctrl;

  localparam int CW = 8;

  typedef struct {
    int kind;  // 0 w_rd, 1 switch, 2 valid, 3 out, 4 done
    int lane;
    int cyc;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "w_rd";
      1: return "switch";
      2: return "valid";
      3: return "out";
      default: return "done";
    endcase
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void flag_fail(input string nm, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int NN = (gi == 0) ? 2 : 4;
    localparam int RW = (NN > 1) ? $clog2(NN) : 1;

    logic            rst_g = 1'b1;
    logic            start = 1'b0;
    logic [CW-1:0]   nv = '0;
    logic            busy, done, w_rd_en;
    logic [RW-1:0]   w_rd_row;
    logic [NN-1:0]   accept_w, switch_row, valid_row, out_valid;
    logic [NN*CW-1:0] in_idx, out_idx;
    ev_t             q[$];
    int              busy_from = 1;
    int              busy_to = 0;
    bit              fin = 1'b0;

    systolic_ctrl #(.N(NN), .CW(CW)) dut (
      .clk(clk), .rst(rst_g), .start(start), .num_vecs(nv),
      .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_row(w_rd_row),
      .accept_w(accept_w), .switch_row(switch_row), .valid_row(valid_row),
      .in_idx(in_idx), .out_valid(out_valid), .out_idx(out_idx)
    );

    // Timeline of one job whose start is sampled in cycle c0; returns the done cycle.
    function automatic int model(input int c0, input int m);
      int s;
      if (m == 0) begin
        q.push_back(ev_t'{4, 0, c0 + 1, 0});
        busy_from = c0 + 1;
        busy_to   = c0;
        return c0 + 1;
      end
      s = c0 + NN + 1;
      for (int k = 0; k < NN; k++) q.push_back(ev_t'{0, 0, c0 + 1 + k, NN - 1 - k});
      for (int r = 0; r < NN; r++) begin
        q.push_back(ev_t'{1, r, s + r, 0});
        for (int v = 0; v < m; v++) begin
          q.push_back(ev_t'{2, r, s + r + v, v});
          q.push_back(ev_t'{3, r, s + NN + r + v, v});
        end
      end
      q.push_back(ev_t'{4, 0, s + 2 * NN + m - 1, 0});
      busy_from = c0 + 1;
      busy_to   = s + 2 * NN + m - 2;
      return s + 2 * NN + m - 1;
    endfunction

    // mode 0: quiet, 1: random start noise while busy, 2: fixed pulses at +2/+6 with num_vecs=7
    task automatic job(input int m, input int mode, input int abort_at);
      int c0, dn;
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b1;
      nv = CW'(m);
      dn = model(c0, m);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = c0 + 1; c < dn; c++) begin
        if (abort_at > 0 && c == c0 + abort_at) begin
          rst_g = 1'b1;
          q.delete();
          busy_to = c - 1;
          @(posedge clk); #1;
          rst_g = 1'b0;
          break;
        end
        if (mode == 1) begin
          start = ($urandom_range(0, 2) == 0);
          nv = CW'($urandom);
        end else if (mode == 2) begin
          start = (c == c0 + 2) || (c == c0 + 6);
          if (c == c0 + 2) nv = CW'(7);
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("n%0d_queue_drained", NN), q.size(), 0);
      $display("n%0d job m=%0d mode=%0d abort=%0d start_cycle=%0d", NN, m, mode, abort_at, c0);
    endtask

    always @(negedge clk) begin
      int on, idx, found;
      if (rst_g) begin
        chk($sformatf("n%0d_rst_busy", NN), int'(busy), 0);
        chk($sformatf("n%0d_rst_done", NN), int'(done), 0);
        chk($sformatf("n%0d_rst_w_rd_en", NN), int'(w_rd_en), 0);
        chk($sformatf("n%0d_rst_w_rd_row", NN), int'(w_rd_row), 0);
        chk($sformatf("n%0d_rst_accept_w", NN), int'(accept_w), 0);
        chk($sformatf("n%0d_rst_switch", NN), int'(switch_row), 0);
        chk($sformatf("n%0d_rst_valid", NN), int'(valid_row), 0);
        chk($sformatf("n%0d_rst_out_valid", NN), int'(out_valid), 0);
        chk($sformatf("n%0d_rst_in_idx", NN), int'(in_idx != '0), 0);
        chk($sformatf("n%0d_rst_out_idx", NN), int'(out_idx != '0), 0);
      end else begin
        chk($sformatf("n%0d_busy", NN), int'(busy),
            int'(cyc >= busy_from && cyc <= busy_to));
        chk($sformatf("n%0d_accept_w", NN), int'(accept_w),
            w_rd_en ? (1 << NN) - 1 : 0);
        if (!w_rd_en) chk($sformatf("n%0d_w_rd_row_idle", NN), int'(w_rd_row), 0);
        for (int k = 0; k < 5; k++) begin
          for (int l = 0; l < NN; l++) begin
            on = 0;
            idx = 0;
            case (k)
              0: if (l == 0) begin on = int'(w_rd_en); idx = int'(w_rd_row); end
              1: on = int'(switch_row[l]);
              2: begin on = int'(valid_row[l]); idx = int'(in_idx[l*CW +: CW]); end
              3: begin on = int'(out_valid[l]); idx = int'(out_idx[l*CW +: CW]); end
              default: if (l == 0) on = int'(done);
            endcase
            if (on != 0) begin
              found = -1;
              for (int i = 0; i < q.size(); i++) begin
                if (q[i].kind == k && q[i].lane == l) begin
                  found = i;
                  break;
                end
              end
              if (found < 0) begin
                flag_fail($sformatf("n%0d_unexpected_%s%0d", NN, kname(k), l), 1, 0);
              end else begin
                chk($sformatf("n%0d_%s%0d_cycle", NN, kname(k), l), cyc, q[found].cyc);
                chk($sformatf("n%0d_%s%0d_idx", NN, kname(k), l), idx, q[found].idx);
                q.delete(found);
              end
            end else if (k == 2 || k == 3) begin
              chk($sformatf("n%0d_%s%0d_idx_zero", NN, kname(k), l), idx, 0);
            end
          end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].cyc <= cyc) begin
            flag_fail($sformatf("n%0d_missed_%s%0d", NN, kname(q[i].kind), q[i].lane),
                      0, q[i].cyc);
            q.delete(i);
          end
        end
      end
    end

    initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_g = 1'b0;
      if (NN == 2) begin
        job(3, 0, 0);
        job(0, 0, 0);
        job(3, 2, 0);
        job(3, 0, 4);
        job(3, 0, 0);
        job(255, 0, 0);
      end else begin
        job(1, 0, 0);
        job(0, 0, 0);
        job(2, 0, 0);
      end
      for (int j = 0; j < 8; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        job(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)), 1, 0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && w < 20000) begin
      @(posedge clk);
      w++;
    end
    chk("finish_within_budget", int'(w < 20000), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
